spu_host_driver: RTL and testbench
==================================

# spu_host_driver

Host-side sequencer for the tinySPU pin interface. Accepts one operation request (opcode plus operands A/B/C/D) over a valid/ready handshake, drives the SPU's `ui_in`/`uio_in` pins through the load-A/B, load-C/D and execute phases, then captures the M/N result from `uo_out`. The result is returned on a second valid/ready handshake. Sits between an on-chip controller or bench harness and the SPU.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each phase is held on the SPU pins; legal range 1..15.

Ports:
- `clk`  in  1  system clock; one clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  4  SPU opcode.
- `req_a`, `req_b`, `req_c`, `req_d`  in  4 each  operands.
- `req_reload`  in  1  1 = run both load phases; 0 = skip the loads and reuse the operands already in the SPU.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_m`, `rsp_n`  out  4 each  captured `spu_uo[7:4]` and `spu_uo[3:0]`.
- `rsp_op`  out  4  opcode that produced the result.
- `spu_ui`  out  8  to SPU `ui_in`: {Op, Q}.
- `spu_uio`  out  8  to SPU `uio_in`: {A,B} or {C,D}.
- `spu_ena`  out  1  to SPU `ena`.
- `spu_uo`  in  8  from SPU `uo_out`.
- `busy`  out  1  high whenever state is not IDLE.
- `op_count`  out  16  completed-transaction count (see Configuration).

## Operation
States and the pins they drive:
- IDLE:
  - `spu_ui` = 0x00, `spu_uio` = 0x00, `spu_ena` = 0.
  - `req_ready` = 1.
  - On `req_valid`, latch op, operands and reload.
  - Next state is LOAD_AB if reload = 1, otherwise EXEC.
- LOAD_AB:
  - `spu_ui` = {0000, 0110}, `spu_uio` = {A,B}, `spu_ena` = 1.
  - After SETTLE_CYCLES, go to LOAD_CD.
- LOAD_CD:
  - `spu_ui` = {0000, 0101}, `spu_uio` = {C,D}, `spu_ena` = 1.
  - After SETTLE_CYCLES, go to EXEC.
- EXEC:
  - `spu_ui` = {op, 0000}, `spu_uio` = 0x00, `spu_ena` = 1.
  - On the last of its SETTLE_CYCLES cycles, register `spu_uo` into `rsp_m`/`rsp_n` and `op` into `rsp_op`, then go to RESP.
- RESP:
  - Pins are held exactly as in EXEC.
  - `rsp_valid` = 1.
  - On `rsp_ready`, go to IDLE.

Phase counter:
- 4 bits; loaded with SETTLE_CYCLES-1 on entry to each phase.
- Decrements once per cycle; the phase ends in the cycle it reads 0.

Other rules:
- Pin outputs are decoded from the state register and the latched operands. They change only on clock edges.
- `rsp_m`, `rsp_n` and `rsp_op` hold their value until the next capture.
- Request inputs are ignored outside IDLE. Changing `req_*` mid-transaction has no effect.

## Timing
Reset values:
- State IDLE.
- `req_ready` = 1; `busy`, `rsp_valid` and `spu_ena` = 0.
- `spu_ui`, `spu_uio`, `rsp_m`, `rsp_n`, `rsp_op` = 0; `op_count` = 0.

Latency, with S = SETTLE_CYCLES and request accepted at edge 0:
- reload = 1: `rsp_valid` rises after edge 3S.
- reload = 0: `rsp_valid` rises after edge S.
- Earliest next acceptance: the edge after the `rsp_valid && rsp_ready` edge, because IDLE is re-entered for at least one cycle. Throughput with reload = 1 is one transaction per 3S+2 cycles.

Boundary cases:
- `rsp_ready` already high on the cycle RESP is entered: handshake completes at the next edge.
- `rsp_ready` low: RESP holds indefinitely with all outputs stable.
- Reset asserted in any state: returns to IDLE asynchronously with the reset values. No partial result is delivered.

## Configuration
- `SPU_DRV_STATS_EN` defined:
  - `op_count` increments by 1 on each `rsp_valid && rsp_ready` edge.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared by `rst`.
- `SPU_DRV_STATS_EN` undefined:
  - `op_count` is tied to 0 and no counter logic is present.
  - All other behaviour is identical.

## Test plan
- Reset: `rst` pulse mid-bench → all outputs at their reset values while `rst` is high; `req_ready` = 1 after release.
- Full transaction, S = 2, op = 3, A/B/C/D = 4/5/6/7, reload = 1, `rsp_ready` = 1, model SPU drives `spu_uo` = 0x9B in EXEC → required response:
  - `spu_ui`/`spu_uio` read 0x06/0x45 for 2 cycles, then 0x05/0x67 for 2 cycles, then 0x30/0x00 for 2 cycles.
  - `rsp_valid` rises 6 cycles after acceptance with `rsp_m` = 9, `rsp_n` = 0xB, `rsp_op` = 3.
- reload = 0, op = 0xA, model returns 0x12 → only the 0xA0 phase appears on `spu_ui`; `rsp_valid` rises after 2 cycles with M = 1, N = 2.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`, `rsp_m`/`rsp_n`, `spu_ui` and `busy` stay stable; `req_ready` = 0; a second `req_valid` is not accepted.
- Reset mid-operation: assert `rst` in LOAD_CD → IDLE immediately, `spu_ena` = 0, `rsp_valid` never rises. A fresh request afterwards completes normally.
- `SPU_DRV_STATS_EN` defined: 3 back-to-back transactions → `op_count` = 3. With the macro undefined, the same stimulus leaves `op_count` = 0.

Source files
------------

// File: rtl/spu_host_driver.sv
// Host-side sequencer driving tinySPU pins: load A/B, load C/D, execute, capture.
// Define SPU_DRV_STATS_EN to enable the completed-transaction counter on op_count.
module spu_host_driver #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [3:0] req_c,
  input  logic [3:0] req_d,
  input  logic       req_reload,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_m,
  output logic [3:0] rsp_n,
  output logic [3:0] rsp_op,
  output logic [7:0] spu_ui,
  output logic [7:0] spu_uio,
  output logic       spu_ena,
  input  logic [7:0] spu_uo,
  output logic       busy,
  output logic [15:0] op_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LAB  = 3'd1;
  localparam logic [2:0] S_LCD  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic [3:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] c_q;
  logic [3:0] d_q;
  logic       accept;
  logic       phase_end;
  logic       done;

  assign accept    = req_valid && (state == S_IDLE);
  assign phase_end = (cnt == 4'd0);
  assign done      = (state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      op_q   <= 4'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      c_q    <= 4'd0;
      d_q    <= 4'd0;
      rsp_m  <= 4'd0;
      rsp_n  <= 4'd0;
      rsp_op <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            c_q   <= req_c;
            d_q   <= req_d;
            cnt   <= CNT_INIT;
            state <= req_reload ? S_LAB : S_EXEC;
          end
        end
        S_LAB: begin
          if (phase_end) begin
            cnt   <= CNT_INIT;
            state <= S_LCD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LCD: begin
          if (phase_end) begin
            cnt   <= CNT_INIT;
            state <= S_EXEC;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_EXEC: begin
          if (phase_end) begin
            rsp_m  <= spu_uo[7:4];
            rsp_n  <= spu_uo[3:0];
            rsp_op <= op_q;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RESP keeps the execute pins applied so the SPU output stays valid
  always_comb begin
    spu_ui    = 8'h00;
    spu_uio   = 8'h00;
    spu_ena   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LAB: begin
        spu_ui  = 8'h06;
        spu_uio = {a_q, b_q};
        spu_ena = 1'b1;
      end
      S_LCD: begin
        spu_ui  = 8'h05;
        spu_uio = {c_q, d_q};
        spu_ena = 1'b1;
      end
      S_EXEC: begin
        spu_ui  = {op_q, 4'h0};
        spu_ena = 1'b1;
      end
      S_RESP: begin
        spu_ui    = {op_q, 4'h0};
        spu_ena   = 1'b1;
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

`ifdef SPU_DRV_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else if (done) cnt_q <= cnt_q + 16'd1;
  end

  assign op_count = cnt_q;
`else
  logic unused_done;

  assign unused_done = done;
  assign op_count    = 16'd0;
`endif

endmodule

// File: tb/tb_spu_host_driver.sv
// Directed self-checking bench for spu_host_driver with a tiny SPU model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spu_host_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] req_c;
  logic [3:0] req_d;
  logic       req_reload;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_m;
  logic [3:0] rsp_n;
  logic [3:0] rsp_op;
  logic [7:0] spu_ui;
  logic [7:0] spu_uio;
  logic       spu_ena;
  logic [7:0] spu_uo;
  logic       busy;
  logic [15:0] op_count;

  logic [7:0] model_res;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // SPU model: presents its result only while an execute opcode is applied
  assign spu_uo = (spu_ena && spu_ui[3:0] == 4'h0) ? model_res : 8'h00;

  spu_host_driver #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_d(req_d), .req_reload(req_reload),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_m(rsp_m), .rsp_n(rsp_n), .rsp_op(rsp_op),
    .spu_ui(spu_ui), .spu_uio(spu_uio), .spu_ena(spu_ena),
    .spu_uo(spu_uo), .busy(busy), .op_count(op_count)
  );

  task automatic issue(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic rl);
    req_op = op; req_a = a; req_b = b; req_c = c; req_d = d;
    req_reload = rl;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 4'hF; req_a = 4'hF; req_b = 4'hF;
    req_c = 4'hF; req_d = 4'hF; req_reload = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    @(negedge clk);
    tests++;
    if ({req_ready, busy, rsp_valid, spu_ena} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 1000",
               {req_ready, busy, rsp_valid, spu_ena});
    end
    tests++;
    if ({spu_ui, spu_uio, rsp_m, rsp_n, rsp_op, op_count} !== 44'h0) begin
      fails++;
      $display("FAIL reset_data got %h want 0",
               {spu_ui, spu_uio, rsp_m, rsp_n, rsp_op, op_count});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_full;
    logic [7:0] ui_exp [6];
    logic [7:0] uio_exp [6];
    ui_exp  = '{8'h06, 8'h06, 8'h05, 8'h05, 8'h30, 8'h30};
    uio_exp = '{8'h45, 8'h45, 8'h67, 8'h67, 8'h00, 8'h00};
    model_res = 8'h9B;
    rsp_ready = 1'b1;
    issue(4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if ({spu_ui, spu_uio, spu_ena, rsp_valid} !==
          {ui_exp[i], uio_exp[i], 2'b10}) begin
        fails++;
        $display("FAIL full_phase%0d got ui=%h uio=%h ena=%b v=%b want %h %h 1 0",
                 i, spu_ui, spu_uio, spu_ena, rsp_valid, ui_exp[i], uio_exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if ({rsp_valid, rsp_m, rsp_n, rsp_op} !== {1'b1, 4'h9, 4'hB, 4'h3}) begin
      fails++;
      $display("FAIL full_rsp got v=%b m=%h n=%h op=%h want 1 9 b 3",
               rsp_valid, rsp_m, rsp_n, rsp_op);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL full_idle got v/rdy/busy=%b want 010",
               {rsp_valid, req_ready, busy});
    end
  endtask

  task automatic test_noreload;
    model_res = 8'h12;
    rsp_ready = 1'b1;
    issue(4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({spu_ui, spu_uio, rsp_valid} !== {8'hA0, 8'h00, 1'b0}) begin
        fails++;
        $display("FAIL noreload_phase%0d got ui=%h uio=%h v=%b want a0 00 0",
                 i, spu_ui, spu_uio, rsp_valid);
      end
      @(negedge clk);
    end
    tests++;
    if ({rsp_valid, rsp_m, rsp_n, rsp_op} !== {1'b1, 4'h1, 4'h2, 4'hA}) begin
      fails++;
      $display("FAIL noreload_rsp got v=%b m=%h n=%h op=%h want 1 1 2 a",
               rsp_valid, rsp_m, rsp_n, rsp_op);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    model_res = 8'h3C;
    rsp_ready = 1'b0;
    issue(4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    req_op = 4'h9; req_reload = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({rsp_valid, rsp_m, rsp_n, spu_ui, busy, req_ready} !==
          {1'b1, 4'h3, 4'hC, 8'h50, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%b m=%h n=%h ui=%h busy=%b rdy=%b want 1 3 c 50 1 0",
                 i, rsp_valid, rsp_m, rsp_n, spu_ui, busy, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({rsp_valid, busy, req_ready, rsp_m, rsp_op} !=
        {3'b001, 4'h3, 4'h5}) begin
      fails++;
      $display("FAIL bp_release got v=%b busy=%b rdy=%b m=%h op=%h want 0 0 1 3 5",
               rsp_valid, busy, req_ready, rsp_m, rsp_op);
    end
  endtask

  task automatic test_reset_midop;
    bit seen;
    model_res = 8'hEE;
    rsp_ready = 1'b1;
    issue(4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (spu_ui !== 8'h05) begin
      fails++;
      $display("FAIL midop_lcd got ui=%h want 05", spu_ui);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, spu_ena, rsp_valid, req_ready, spu_ui, rsp_m} !==
        {4'b0001, 8'h00, 4'h0}) begin
      fails++;
      $display("FAIL midop_async got busy=%b ena=%b v=%b rdy=%b ui=%h m=%h want 0 0 0 1 00 0",
               busy, spu_ena, rsp_valid, req_ready, spu_ui, rsp_m);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL midop_quiet got activity=%b want 0", seen);
    end
    model_res = 8'h5E;
    issue(4'h7, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    tests++;
    if ({spu_ui, spu_uio} !== 16'h0612) begin
      fails++;
      $display("FAIL midop_fresh_ab got %h want 0612", {spu_ui, spu_uio});
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({spu_ui, spu_uio} !== 16'h0534) begin
      fails++;
      $display("FAIL midop_fresh_cd got %h want 0534", {spu_ui, spu_uio});
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_m, rsp_n, rsp_op} !== {1'b1, 4'h5, 4'hE, 4'h7}) begin
      fails++;
      $display("FAIL midop_fresh_rsp got v=%b m=%h n=%h op=%h want 1 5 e 7",
               rsp_valid, rsp_m, rsp_n, rsp_op);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] res [3];
    logic [15:0] exp_cnt;
    res = '{8'hA1, 8'hB2, 8'hC3};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (req_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d got %b want 1", t, req_ready);
      end
      model_res = res[t];
      issue(4'(t + 1), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_m, rsp_n} !== {1'b1, res[t]}) begin
        fails++;
        $display("FAIL b2b_rsp%0d got v=%b mn=%h%h want 1 %h",
                 t, rsp_valid, rsp_m, rsp_n, res[t]);
      end
      @(negedge clk);
    end
`ifdef SPU_DRV_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    tests++;
    if (op_count !== exp_cnt) begin
      fails++;
      $display("FAIL b2b_count got %0d want %0d", op_count, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 4'h0; req_a = 4'h0; req_b = 4'h0;
    req_c = 4'h0; req_d = 4'h0; req_reload = 1'b0;
    rsp_ready = 1'b0;
    model_res = 8'h00;
    test_reset;
    test_full;
    test_noreload;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
